fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the instruction queue. Owns the PC,
//  issues one 32-bit read at a time to the I-cache, and enqueues {pc, inst} packets
//  into the instruction queue. Stalls on queue full; redirects on global_branch_signal
//  and discards any in-flight cache response belonging to the squashed path.
// PARAMETERS
//  RESET_PC    32'h1eceb000   PC value loaded on reset
//  DATA_WIDTH  32             instruction and PC width
// PORTS
//  clk                   in   1   single clock
//  rst_n                 in   1   one clock; reset is synchronous and active-low
//  global_branch_signal  in   1   flush/redirect pulse, same signal the queue receives
//  branch_target_pc      in   32  redirect PC, valid while global_branch_signal=1
//  queue_full_in         in   1   queue full_out; no enqueue allowed while 1
//  enqueue_out           out  1   queue enqueue_in strobe
//  wdata_out             out  64  queue wdata_in = {pc[63:32], inst[31:0]} (fetch_pkt_t)
//  imem_addr             out  32  I-cache read address, 4-byte aligned
//  imem_rmask            out  4   4'hF while a read is outstanding, else 4'h0
//  imem_rdata            in   32  I-cache read data, valid when imem_resp=1
//  imem_resp             in   1   I-cache response strobe, one cycle
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): pc=RESET_PC, state=IDLE, hold buffer cleared;
//   enqueue_out=0, wdata_out=0, imem_rmask=0, imem_addr=RESET_PC.
//  Request contract: imem_rmask=4'hF and imem_addr stable from the issue cycle through
//   the imem_resp cycle inclusive; one outstanding read max; rmask drops the cycle after resp.
//  States (fetch_state_t):
//   IDLE: branch -> pc=target&~3, stay IDLE. Else if !queue_full_in -> issue read at pc, go WAIT.
//    imem_resp seen in IDLE is ignored.
//   WAIT: branch & resp -> drop data, pc=target, IDLE. branch & !resp -> pc=target, DISCARD.
//    resp & !queue_full_in -> enqueue_out=1 with {pc, imem_rdata} same cycle (combinational),
//    pc+=4, IDLE. resp & queue_full_in -> capture {pc, rdata} into hold buffer, HOLD.
//   HOLD: branch -> drop buffer, pc=target, IDLE. else !queue_full_in -> enqueue buffer,
//    pc+=4, IDLE. else stay.
//   DISCARD: keep rmask/addr of squashed read; resp -> drop, IDLE. branch again -> pc=new
//    target, stay DISCARD. Never enqueues.
//  enqueue_out is never 1 in a cycle where global_branch_signal=1 or queue_full_in=1.
//  wdata_out=0 whenever enqueue_out=0.
//  Throughput: 1 packet per 2 cycles minimum (issue cycle + resp cycle on 1-cycle hit).
//  PC arithmetic: 32-bit add, wraps 32'hFFFFFFFC -> 32'h0 silently; target low 2 bits forced 0.
//  Branch has priority over every other event in every state.
// STRUCTURE
//  rv32i_types additions: fetch_state_t enum {IDLE, WAIT, HOLD, DISCARD};
//   fetch_pkt_t packed struct {logic [31:0] pc; logic [31:0] inst;} (queue DATA_WIDTH=64).
//  Single module, no sub-modules: PC reg, state reg, 64-bit hold buffer, next-state comb.
// TESTING
//  1 Reset, cache 1-cycle hits, queue never full -> enqueues pc 1eceb000,1eceb004,
//    1eceb008 on every 2nd cycle, inst matches imem_rdata.
//  2 queue_full_in=1 at resp for pc 1eceb004 for 5 cycles -> no enqueue, rmask=0 after
//    resp; enqueue {1eceb004, inst} in the cycle full drops; no duplicate, no loss.
//  3 branch to 1ecec100 in WAIT, resp 3 cycles later -> that resp dropped, next request
//    addr=1ecec100, first enqueued pc=1ecec100.
//  4 branch coincident with resp (target 1ecec203) -> nothing enqueued, next addr=1ecec200.
//  5 branch in HOLD -> buffer dropped; second branch during DISCARD -> last target wins.
//  6 rst_n=0 mid-WAIT -> all outputs at reset values next cycle; stale resp in IDLE
//    ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM states, queue packet layout
// and PC alignment helper.
package fetch_unit_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h1eceb000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one I-cache read in flight and
// pushes {pc, inst} packets into the instruction queue.
//
// Handshakes: a read is presented with imem_rmask=4'hF and a stable imem_addr from
// the issue cycle through the imem_resp cycle; a queue push happens in any cycle
// with enqueue_out=1 and is only legal while queue_full_in=0.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    global_branch_signal,
  input  logic [DATA_WIDTH-1:0]   branch_target_pc,
  input  logic                    queue_full_in,
  output logic                    enqueue_out,
  output logic [2*DATA_WIDTH-1:0] wdata_out,
  output logic [DATA_WIDTH-1:0]   imem_addr,
  output logic [3:0]              imem_rmask,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  input  logic                    imem_resp,
  output fetch_state_t            o_dbg_state
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_addr;
  fetch_pkt_t   r_hold;

  logic         w_issue;
  logic         w_enq;
  fetch_pkt_t   w_pkt;
  logic [31:0]  w_target;

  assign w_target = align_pc(branch_target_pc);

  // Issue and enqueue decisions are combinational so a 1-cycle hit sustains
  // one packet every two cycles; a branch suppresses both in every state.
  always_comb begin
    w_issue = 1'b0;
    w_enq   = 1'b0;
    w_pkt   = '0;
    case (r_state)
      IDLE: w_issue = rst_n && !global_branch_signal && !queue_full_in;
      WAIT: begin
        if (rst_n && !global_branch_signal && imem_resp && !queue_full_in) begin
          w_enq = 1'b1;
          w_pkt = '{pc: r_pc, inst: imem_rdata};
        end
      end
      HOLD: begin
        if (rst_n && !global_branch_signal && !queue_full_in) begin
          w_enq = 1'b1;
          w_pkt = r_hold;
        end
      end
      default: ;
    endcase
  end

  assign enqueue_out = w_enq;
  assign wdata_out   = w_pkt;
  assign imem_rmask  = (w_issue || r_state == WAIT || r_state == DISCARD) ? 4'hF : 4'h0;
  // A squashed read keeps its original address until its response retires it.
  assign imem_addr   = (r_state == WAIT || r_state == DISCARD) ? r_req_addr : r_pc;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_hold     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (global_branch_signal) begin
            r_pc <= w_target;
          end else if (w_issue) begin
            r_req_addr <= r_pc;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (global_branch_signal) begin
            r_pc    <= w_target;
            r_state <= imem_resp ? IDLE : DISCARD;
          end else if (imem_resp) begin
            if (!queue_full_in) begin
              r_pc    <= r_pc + 32'd4;
              r_state <= IDLE;
            end else begin
              r_hold  <= '{pc: r_pc, inst: imem_rdata};
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (global_branch_signal) begin
            r_hold  <= '0;
            r_pc    <= w_target;
            r_state <= IDLE;
          end else if (!queue_full_in) begin
            r_hold  <= '0;
            r_pc    <= r_pc + 32'd4;
            r_state <= IDLE;
          end
        end
        DISCARD: begin
          // The outstanding response must still retire even if another branch lands.
          if (global_branch_signal) r_pc <= w_target;
          if (imem_resp)            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-scenario tasks with hand-computed expected
// outputs plus an enqueue scoreboard that catches lost or duplicated packets.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         global_branch_signal;
  logic [31:0]  branch_target_pc;
  logic         queue_full_in;
  logic         enqueue_out;
  logic [63:0]  wdata_out;
  logic [31:0]  imem_addr;
  logic [3:0]   imem_rmask;
  logic [31:0]  imem_rdata;
  logic         imem_resp;
  fetch_state_t o_dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] act_q[$];
  logic [100:0] obs;
  logic [100:0] want;

  fetch_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .global_branch_signal (global_branch_signal),
    .branch_target_pc     (branch_target_pc),
    .queue_full_in        (queue_full_in),
    .enqueue_out          (enqueue_out),
    .wdata_out            (wdata_out),
    .imem_addr            (imem_addr),
    .imem_rmask           (imem_rmask),
    .imem_rdata           (imem_rdata),
    .imem_resp            (imem_resp),
    .o_dbg_state          (o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {enqueue_out, wdata_out, imem_rmask, imem_addr};

  // Monitor: every accepted queue push
  always @(posedge clk) begin
    if (rst_n && enqueue_out) act_q.push_back(wdata_out);
  end

  function automatic logic [100:0] ev(input logic e, input logic [63:0] w,
                                      input logic [3:0] m, input logic [31:0] a);
    return {e, w, m, a};
  endfunction

  // Driver: apply one cycle of inputs at the falling edge, outputs settle by +1
  task automatic drive(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic full, input logic resp, input logic [31:0] rd);
    @(negedge clk);
    rst_n = rst; global_branch_signal = br; branch_target_pc = tgt;
    queue_full_in = full; imem_resp = resp; imem_rdata = rd;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hdeadbeef);
    want = ev(1'b0, 64'h0, 4'h0, 32'h1eceb000);
    if (obs !== want) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, want); end
    n_cmp++;
    if (o_dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", o_dbg_state, IDLE); end
    n_cmp++;
  endtask

  task automatic test_basic_hits();
    logic [31:0] pcs [3];
    logic [31:0] insts [3];
    pcs   = '{32'h1eceb000, 32'h1eceb004, 32'h1eceb008};
    insts = '{32'h00100093, 32'h00208113, 32'h00310193};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      want = ev(1'b0, 64'h0, 4'hF, pcs[i]);
      if (obs !== want) begin n_fail++; $display("FAIL basic_issue%0d: got %h want %h", i, obs, want); end
      n_cmp++;
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, insts[i]);
      want = ev(1'b1, {pcs[i], insts[i]}, 4'hF, pcs[i]);
      if (obs !== want) begin n_fail++; $display("FAIL basic_enq%0d: got %h want %h", i, obs, want); end
      n_cmp++;
      exp_q.push_back({pcs[i], insts[i]});
    end
  endtask

  task automatic test_queue_full();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11111111);
    exp_q.push_back({32'h1eceb000, 32'h11111111});
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h22222222);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1eceb004);
    if (obs !== want) begin n_fail++; $display("FAIL full_resp: got %h want %h", obs, want); end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      if (obs[100:36] !== 65'h0 || imem_rmask !== 4'h0) begin
        n_fail++; $display("FAIL full_hold%0d: got %h want enq=0 wdata=0 rmask=0", i, obs);
      end
      n_cmp++;
    end
    if (o_dbg_state !== HOLD) begin n_fail++; $display("FAIL full_state: got %0d want %0d", o_dbg_state, HOLD); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    if (obs[100:36] !== {1'b1, 32'h1eceb004, 32'h22222222} || imem_rmask !== 4'h0) begin
      n_fail++; $display("FAIL full_release: got %h want enq {1eceb004,22222222} rmask 0", obs);
    end
    n_cmp++;
    exp_q.push_back({32'h1eceb004, 32'h22222222});
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1eceb008);
    if (obs !== want) begin n_fail++; $display("FAIL full_next_issue: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h33333333);
    exp_q.push_back({32'h1eceb008, 32'h33333333});
  endtask

  task automatic test_branch_wait();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h1ecec100, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1eceb000);
    if (obs !== want) begin n_fail++; $display("FAIL brw_branch: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1eceb000);
    if (obs !== want) begin n_fail++; $display("FAIL brw_discard_hold: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h44444444);
    if (enqueue_out !== 1'b0) begin n_fail++; $display("FAIL brw_stale_resp: got enq %b want 0", enqueue_out); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1ecec100);
    if (obs !== want) begin n_fail++; $display("FAIL brw_new_issue: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55555555);
    want = ev(1'b1, {32'h1ecec100, 32'h55555555}, 4'hF, 32'h1ecec100);
    if (obs !== want) begin n_fail++; $display("FAIL brw_first_enq: got %h want %h", obs, want); end
    n_cmp++;
    exp_q.push_back({32'h1ecec100, 32'h55555555});
  endtask

  task automatic test_branch_resp();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h1ecec203, 1'b0, 1'b1, 32'h66666666);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1eceb000);
    if (obs !== want) begin n_fail++; $display("FAIL brr_coincident: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'h0, 32'h1ecec200);
    if (obs !== want) begin n_fail++; $display("FAIL brr_idle_full: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1ecec200);
    if (obs !== want) begin n_fail++; $display("FAIL brr_aligned_issue: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77777777);
    exp_q.push_back({32'h1ecec200, 32'h77777777});
  endtask

  task automatic test_branch_hold_discard();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h88888888);
    drive(1'b1, 1'b1, 32'h1ecec300, 1'b0, 1'b0, 32'h0);
    if (obs[100:36] !== 65'h0) begin n_fail++; $display("FAIL hold_branch: got %h want enq=0 wdata=0", obs); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1ecec300);
    if (obs !== want) begin n_fail++; $display("FAIL hold_redirect_issue: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b1, 32'h1ecec400, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h1ecec500, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1ecec300);
    if (obs !== want) begin n_fail++; $display("FAIL discard_rebranch: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h99999999);
    if (enqueue_out !== 1'b0) begin n_fail++; $display("FAIL discard_resp: got enq %b want 0", enqueue_out); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1ecec500);
    if (obs !== want) begin n_fail++; $display("FAIL discard_last_target: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'haaaaaaaa);
    exp_q.push_back({32'h1ecec500, 32'haaaaaaaa});
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hbbbbbbbb);
    want = ev(1'b0, 64'h0, 4'h0, 32'h1eceb000);
    if (obs !== want) begin n_fail++; $display("FAIL rst_mid_outputs: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hcccccccc);
    want = ev(1'b0, 64'h0, 4'hF, 32'h1eceb000);
    if (obs !== want) begin n_fail++; $display("FAIL rst_idle_stale_resp: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hdddddddd);
    want = ev(1'b1, {32'h1eceb000, 32'hdddddddd}, 4'hF, 32'h1eceb000);
    if (obs !== want) begin n_fail++; $display("FAIL rst_restart_enq: got %h want %h", obs, want); end
    n_cmp++;
    exp_q.push_back({32'h1eceb000, 32'hdddddddd});
  endtask

  task automatic test_pc_wrap();
    drive(1'b1, 1'b1, 32'hffffffff, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'h0, 32'h1eceb004);
    if (obs !== want) begin n_fail++; $display("FAIL wrap_idle_branch: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000006f);
    want = ev(1'b1, {32'hfffffffc, 32'h0000006f}, 4'hF, 32'hfffffffc);
    if (obs !== want) begin n_fail++; $display("FAIL wrap_top_enq: got %h want %h", obs, want); end
    n_cmp++;
    exp_q.push_back({32'hfffffffc, 32'h0000006f});
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    want = ev(1'b0, 64'h0, 4'hF, 32'h00000000);
    if (obs !== want) begin n_fail++; $display("FAIL wrap_zero_issue: got %h want %h", obs, want); end
    n_cmp++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00000013);
    exp_q.push_back({32'h00000000, 32'h00000013});
  endtask

  task automatic test_scoreboard();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    if (act_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL sb_count: got %0d packets want %0d", act_q.size(), exp_q.size());
    end
    n_cmp++;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      logic [63:0] e;
      logic [63:0] a;
      e = exp_q.pop_front();
      a = act_q.pop_front();
      if (a !== e) begin n_fail++; $display("FAIL sb_packet: got %h want %h", a, e); end
      n_cmp++;
    end
  endtask

  initial begin
    rst_n = 1'b0; global_branch_signal = 1'b0; branch_target_pc = '0;
    queue_full_in = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
    test_reset();
    test_basic_hits();
    test_queue_full();
    test_branch_wait();
    test_branch_resp();
    test_branch_hold_discard();
    test_reset_mid_wait();
    test_pc_wrap();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
